arp_rx_cache: RTL and testbench

Parametrised successor to the byte-stream ARP receiver.
- Parses ARP payloads (Ethernet header already stripped) from the MAC receive path.
- Fully validates the header and filters on the local IP.
- Stores sender bindings in an N-entry ARP cache with a lookup port for the IP/UDP transmit path.
- Triggers the ARP transmitter to send a reply when a valid request targets the local IP.

---
 rtl/arp_pkg.sv | 35 +++
 rtl/arp_cache.sv | 85 ++++++++
 rtl/arp_rx_cache.sv | 175 +++++++++++++++++
 tb/tb_arp_rx_cache.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arp_pkg.sv
// Shared ARP constants, payload byte offsets and parser state encoding.
package arp_pkg;

  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  ARP_HLEN       = 8'd6;
  localparam logic [7:0]  ARP_PLEN       = 8'd4;
  localparam logic [15:0] ARP_OP_REQ     = 16'd1;
  localparam logic [15:0] ARP_OP_REP     = 16'd2;

  localparam logic [4:0] ARP_OFF_HTYPE = 5'd0;
  localparam logic [4:0] ARP_OFF_PTYPE = 5'd2;
  localparam logic [4:0] ARP_OFF_HLEN  = 5'd4;
  localparam logic [4:0] ARP_OFF_PLEN  = 5'd5;
  localparam logic [4:0] ARP_OFF_OPER  = 5'd6;
  localparam logic [4:0] ARP_OFF_SHA   = 5'd8;
  localparam logic [4:0] ARP_OFF_SPA   = 5'd14;
  localparam logic [4:0] ARP_OFF_THA   = 5'd18;
  localparam logic [4:0] ARP_OFF_TPA   = 5'd24;
  localparam logic [4:0] ARP_OFF_END   = 5'd27;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_SHA, S_SPA, S_THA, S_TPA, S_DECIDE, S_DRAIN
  } arp_state_t;

  // Parser state that owns the byte at payload index idx.
  function automatic arp_state_t arp_field_state(input logic [4:0] idx);
    if (idx < ARP_OFF_SHA)      return S_HDR;
    else if (idx < ARP_OFF_SPA) return S_SHA;
    else if (idx < ARP_OFF_THA) return S_SPA;
    else if (idx < ARP_OFF_TPA) return S_THA;
    else                        return S_TPA;
  endfunction

endpackage

// File: rtl/arp_cache.sv
// N-entry IP->MAC binding store with match/allocate/replace writes and a registered lookup port.
module arp_cache
  import arp_pkg::*;
#(
  parameter int P_CACHE_DEPTH = 4,
  parameter int P_CACHE_AW    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_en,
  input  logic        i_wr_alloc,
  input  logic [31:0] i_wr_ip,
  input  logic [47:0] i_wr_mac,
  input  logic [31:0] i_lookup_ip,
  input  logic        i_lookup_valid,
  output logic [47:0] o_lookup_mac,
  output logic        o_lookup_hit,
  output logic        o_lookup_done
);

  logic [31:0]              r_ip  [P_CACHE_DEPTH];
  logic [47:0]              r_mac [P_CACHE_DEPTH];
  logic [P_CACHE_DEPTH-1:0] r_vld;
  logic [P_CACHE_AW-1:0]    r_ptr;

  logic                  w_match, w_free, w_lk_hit, w_wr_do;
  logic [P_CACHE_AW-1:0] w_match_idx, w_free_idx, w_wr_idx;
  logic [47:0]           w_lk_mac;

  // Lowest index wins for both the write match and the first free slot.
  always_comb begin
    w_match     = 1'b0;
    w_match_idx = '0;
    w_free      = 1'b0;
    w_free_idx  = '0;
    w_lk_hit    = 1'b0;
    w_lk_mac    = '0;
    for (int unsigned i = 0; i < P_CACHE_DEPTH; i++) begin
      if (r_vld[i] && r_ip[i] == i_wr_ip && !w_match) begin
        w_match     = 1'b1;
        w_match_idx = P_CACHE_AW'(i);
      end
      if (!r_vld[i] && !w_free) begin
        w_free     = 1'b1;
        w_free_idx = P_CACHE_AW'(i);
      end
      if (r_vld[i] && r_ip[i] == i_lookup_ip && !w_lk_hit) begin
        w_lk_hit = 1'b1;
        w_lk_mac = r_mac[i];
      end
    end
    w_wr_idx = w_match ? w_match_idx : (w_free ? w_free_idx : r_ptr);
    w_wr_do  = i_wr_en && (w_match || i_wr_alloc);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < P_CACHE_DEPTH; i++) begin
        r_ip[i]  <= '0;
        r_mac[i] <= '0;
      end
      r_vld <= '0;
      r_ptr <= '0;
    end else if (w_wr_do) begin
      r_ip[w_wr_idx]  <= i_wr_ip;
      r_mac[w_wr_idx] <= i_wr_mac;
      r_vld[w_wr_idx] <= 1'b1;
      if (!w_match && !w_free)
        r_ptr <= (r_ptr == P_CACHE_AW'(P_CACHE_DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_lookup_done <= 1'b0;
      o_lookup_hit  <= 1'b0;
      o_lookup_mac  <= '0;
    end else begin
      o_lookup_done <= i_lookup_valid;
      o_lookup_hit  <= i_lookup_valid && w_lk_hit;
      o_lookup_mac  <= (i_lookup_valid && w_lk_hit) ? w_lk_mac : '0;
    end
  end

endmodule

// File: rtl/arp_rx_cache.sv
// ARP payload receiver: validates, filters on local IP, fills arp_cache and triggers replies.
// Define ARP_RX_GRATUITOUS_EN to accept gratuitous ARPs as update-only cache refreshes.
module arp_rx_cache
  import arp_pkg::*;
#(
  parameter logic [31:0] P_LOCAL_IP    = {8'd192, 8'd168, 8'd1, 8'd2},
  parameter int          P_CACHE_DEPTH = 4,
  parameter int          P_CACHE_AW    = 2,
  parameter int          P_DROP_CNT_W  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [31:0]             i_local_ip,
  input  logic                    i_local_ip_valid,
  input  logic [7:0]              i_mac_data,
  input  logic                    i_mac_last,
  input  logic                    i_mac_valid,
  output logic [47:0]             o_target_mac,
  output logic [31:0]             o_target_ip,
  output logic [15:0]             o_target_op,
  output logic                    o_target_valid,
  output logic                    o_trig_reply,
  input  logic [31:0]             i_lookup_ip,
  input  logic                    i_lookup_valid,
  output logic [47:0]             o_lookup_mac,
  output logic                    o_lookup_hit,
  output logic                    o_lookup_done,
  output logic [P_DROP_CNT_W-1:0] o_drop_cnt
);

  arp_state_t  r_state, w_state_nx;
  logic [7:0]  r_data;
  logic        r_last, r_valid, r_last27, r_bad, r_wr_alloc;
  logic [4:0]  r_cnt, w_idx;
  logic [31:0] r_local_ip, r_spa, w_tpa;
  logic [47:0] r_sha;
  logic [23:0] r_tpa;
  logic [15:0] r_oper;
  logic        w_fresh, w_take, w_decide, w_abort, w_byte_bad, w_acc, w_grat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data     <= '0;
      r_last     <= 1'b0;
      r_valid    <= 1'b0;
      r_local_ip <= P_LOCAL_IP;
    end else begin
      r_data  <= i_mac_data;
      r_last  <= i_mac_last;
      r_valid <= i_mac_valid;
      if (i_local_ip_valid) r_local_ip <= i_local_ip;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  // A frame whose byte 27 carried last frees the parser in S_DECIDE, so a
  // back-to-back frame's byte 0 is taken there just as it would be in S_IDLE.
  always_comb begin
    w_fresh    = (r_state == S_IDLE) || (r_state == S_DECIDE && r_last27);
    w_idx      = w_fresh ? '0 : r_cnt;
    w_state_nx = r_state;
    w_take     = 1'b0;
    w_decide   = 1'b0;
    w_abort    = 1'b0;
    if (w_fresh || r_state inside {S_HDR, S_SHA, S_SPA, S_THA, S_TPA}) begin
      if (!r_valid) begin
        w_state_nx = S_IDLE;
        w_abort    = !w_fresh;
      end else begin
        w_take = 1'b1;
        if (w_idx == ARP_OFF_END) begin
          w_decide   = 1'b1;
          w_state_nx = S_DECIDE;
        end else if (r_last) begin
          w_abort    = 1'b1;
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = arp_field_state(w_idx + 5'd1);
        end
      end
    end else if (r_state == S_DECIDE) begin
      w_state_nx = (r_valid && !r_last) ? S_DRAIN : S_IDLE;
    end else if (r_state == S_DRAIN) begin
      if (!r_valid || r_last) w_state_nx = S_IDLE;
    end
  end

  always_comb begin
    w_byte_bad = 1'b0;
    case (w_idx)
      ARP_OFF_HTYPE:         w_byte_bad = r_data != ARP_HTYPE_ETH[15:8];
      ARP_OFF_HTYPE + 5'd1:  w_byte_bad = r_data != ARP_HTYPE_ETH[7:0];
      ARP_OFF_PTYPE:         w_byte_bad = r_data != ARP_PTYPE_IPV4[15:8];
      ARP_OFF_PTYPE + 5'd1:  w_byte_bad = r_data != ARP_PTYPE_IPV4[7:0];
      ARP_OFF_HLEN:          w_byte_bad = r_data != ARP_HLEN;
      ARP_OFF_PLEN:          w_byte_bad = r_data != ARP_PLEN;
      ARP_OFF_OPER:          w_byte_bad = r_data != 8'h00;
      ARP_OFF_OPER + 5'd1:   w_byte_bad = !({r_oper[7:0], r_data} == ARP_OP_REQ ||
                                            {r_oper[7:0], r_data} == ARP_OP_REP);
      default:               w_byte_bad = 1'b0;
    endcase
  end

  assign w_tpa = {r_tpa, r_data};
  assign w_acc = !r_bad && (w_tpa == r_local_ip);
`ifdef ARP_RX_GRATUITOUS_EN
  assign w_grat = !r_bad && (r_spa == w_tpa) && (w_tpa != r_local_ip);
`else
  assign w_grat = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt          <= '0;
      r_bad          <= 1'b0;
      r_last27       <= 1'b0;
      r_oper         <= '0;
      r_sha          <= '0;
      r_spa          <= '0;
      r_tpa          <= '0;
      r_wr_alloc     <= 1'b0;
      o_target_mac   <= '0;
      o_target_ip    <= '0;
      o_target_op    <= '0;
      o_target_valid <= 1'b0;
      o_trig_reply   <= 1'b0;
      o_drop_cnt     <= '0;
    end else begin
      r_cnt <= w_take ? w_idx + 5'd1 : '0;
      if (w_take) begin
        r_bad <= (w_fresh ? 1'b0 : r_bad) | w_byte_bad;
        if (w_idx == ARP_OFF_OPER || w_idx == ARP_OFF_OPER + 5'd1)
          r_oper <= {r_oper[7:0], r_data};
        if (w_idx >= ARP_OFF_SHA && w_idx < ARP_OFF_SPA) r_sha <= {r_sha[39:0], r_data};
        if (w_idx >= ARP_OFF_SPA && w_idx < ARP_OFF_THA) r_spa <= {r_spa[23:0], r_data};
        if (w_idx >= ARP_OFF_TPA && w_idx < ARP_OFF_END) r_tpa <= {r_tpa[15:0], r_data};
      end
      if (w_decide) r_last27 <= r_last;
      o_target_valid <= w_decide && (w_acc || w_grat);
      o_trig_reply   <= w_decide && w_acc && (r_oper == ARP_OP_REQ);
      if (w_decide && (w_acc || w_grat)) begin
        o_target_mac <= r_sha;
        o_target_ip  <= r_spa;
        o_target_op  <= r_oper;
        r_wr_alloc   <= w_acc;
      end
      if ((w_abort || (w_decide && !w_acc && !w_grat)) && o_drop_cnt != '1)
        o_drop_cnt <= o_drop_cnt + 1'b1;
    end
  end

  // Cache writes from the registered outputs, one cycle after they appear,
  // so a lookup issued while o_target_valid is high sees the old contents.
  arp_cache #(
    .P_CACHE_DEPTH (P_CACHE_DEPTH),
    .P_CACHE_AW    (P_CACHE_AW)
  ) u_cache (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_wr_en        (o_target_valid),
    .i_wr_alloc     (r_wr_alloc),
    .i_wr_ip        (o_target_ip),
    .i_wr_mac       (o_target_mac),
    .i_lookup_ip    (i_lookup_ip),
    .i_lookup_valid (i_lookup_valid),
    .o_lookup_mac   (o_lookup_mac),
    .o_lookup_hit   (o_lookup_hit),
    .o_lookup_done  (o_lookup_done)
  );

endmodule

// File: tb/tb_arp_rx_cache.sv
// Randomised and directed bench for arp_rx_cache against a frame-level reference model.
module tb_arp_rx_cache;

  localparam logic [31:0] LOCAL = {8'd192, 8'd168, 8'd1, 8'd2};
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_local_ip = '0;
  logic        i_local_ip_valid = 1'b0;
  logic [7:0]  i_mac_data = '0;
  logic        i_mac_last = 1'b0, i_mac_valid = 1'b0;
  logic [47:0] o_target_mac;
  logic [31:0] o_target_ip;
  logic [15:0] o_target_op;
  logic        o_target_valid, o_trig_reply;
  logic [31:0] i_lookup_ip = '0;
  logic        i_lookup_valid = 1'b0;
  logic [47:0] o_lookup_mac;
  logic        o_lookup_hit, o_lookup_done;
  logic [15:0] o_drop_cnt;

  arp_rx_cache #(
    .P_LOCAL_IP    (LOCAL),
    .P_CACHE_DEPTH (DEPTH),
    .P_CACHE_AW    (2),
    .P_DROP_CNT_W  (16)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (i_rst_n),
    .i_local_ip       (i_local_ip),
    .i_local_ip_valid (i_local_ip_valid),
    .i_mac_data       (i_mac_data),
    .i_mac_last       (i_mac_last),
    .i_mac_valid      (i_mac_valid),
    .o_target_mac     (o_target_mac),
    .o_target_ip      (o_target_ip),
    .o_target_op      (o_target_op),
    .o_target_valid   (o_target_valid),
    .o_trig_reply     (o_trig_reply),
    .i_lookup_ip      (i_lookup_ip),
    .i_lookup_valid   (i_lookup_valid),
    .o_lookup_mac     (o_lookup_mac),
    .o_lookup_hit     (o_lookup_hit),
    .o_lookup_done    (o_lookup_done),
    .o_drop_cnt       (o_drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int          n_cmp = 0, n_bad = 0;
  int          mon_vcnt = 0, mon_rcnt = 0, mon_cyc = 0;
  logic [47:0] mon_mac;
  logic [31:0] mon_ip;
  logic [15:0] mon_op;

  always @(negedge clk) begin
    if (o_target_valid) begin
      mon_vcnt++;
      mon_cyc = cyc;
      mon_mac = o_target_mac;
      mon_ip  = o_target_ip;
      mon_op  = o_target_op;
    end
    if (o_trig_reply) mon_rcnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  fr [64];
  int          fr_len;
  logic [31:0] m_ip  [DEPTH];
  logic [47:0] m_mac [DEPTH];
  bit          m_vld [DEPTH];
  int          m_ptr, m_drop;
  logic [31:0] m_local;

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_vld[i] = 0; m_ip[i] = '0; m_mac[i] = '0;
    end
    m_ptr = 0; m_drop = 0; m_local = LOCAL;
  endtask

  task automatic m_lookup(input logic [31:0] ip, output bit hit, output logic [47:0] mac);
    hit = 0; mac = '0;
    for (int i = 0; i < DEPTH; i++)
      if (m_vld[i] && m_ip[i] == ip) begin hit = 1; mac = m_mac[i]; end
  endtask

  task automatic m_store(input logic [31:0] ip, input logic [47:0] mac, input bit alloc);
    int slot;
    slot = -1;
    for (int i = 0; i < DEPTH; i++) if (m_vld[i] && m_ip[i] == ip) slot = i;
    if (slot < 0 && !alloc) return;
    if (slot < 0)
      for (int i = DEPTH - 1; i >= 0; i--) if (!m_vld[i]) slot = i;
    if (slot < 0) begin
      slot  = m_ptr;
      m_ptr = (m_ptr + 1) % DEPTH;
    end
    m_vld[slot] = 1; m_ip[slot] = ip; m_mac[slot] = mac;
  endtask

  task automatic m_frame(input int gap, output bit acc, output bit grat, output bit rep,
                         output logic [47:0] sha, output logic [31:0] spa, output logic [15:0] op);
    logic [31:0] tpa;
    bit good, whole;
    sha  = {fr[8], fr[9], fr[10], fr[11], fr[12], fr[13]};
    spa  = {fr[14], fr[15], fr[16], fr[17]};
    tpa  = {fr[24], fr[25], fr[26], fr[27]};
    op   = {fr[6], fr[7]};
    good = {fr[0], fr[1]} == 16'h0001 && {fr[2], fr[3]} == 16'h0800 &&
           fr[4] == 8'd6 && fr[5] == 8'd4 && (op == 16'd1 || op == 16'd2);
    whole = fr_len >= 28 && gap < 0;
    acc  = whole && good && tpa == m_local;
    grat = 0;
`ifdef ARP_RX_GRATUITOUS_EN
    grat = whole && good && spa == tpa && tpa != m_local;
`endif
    rep = acc && op == 16'd1;
    if (acc || grat) m_store(spa, sha, acc);
    else if (m_drop < 65535) m_drop++;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic build(input logic [15:0] op, input logic [47:0] sha, input logic [31:0] spa,
                       input logic [31:0] tpa, input int pad);
    fr[0] = 8'h00; fr[1] = 8'h01; fr[2] = 8'h08; fr[3] = 8'h00;
    fr[4] = 8'd6;  fr[5] = 8'd4;  fr[6] = op[15:8]; fr[7] = op[7:0];
    for (int i = 0; i < 6; i++) fr[8 + i]  = sha[47 - 8*i -: 8];
    for (int i = 0; i < 4; i++) fr[14 + i] = spa[31 - 8*i -: 8];
    for (int i = 0; i < 6; i++) fr[18 + i] = 8'($urandom);
    for (int i = 0; i < 4; i++) fr[24 + i] = tpa[31 - 8*i -: 8];
    for (int i = 0; i < pad; i++) fr[28 + i] = 8'($urandom);
    fr_len = 28 + pad;
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic send(input int gap, input int rst_at, output int t27);
    t27 = -1;
    for (int i = 0; i < fr_len; i++) begin
      if (i == gap) begin
        i_mac_valid = 1'b0; @(posedge clk); #1; break;
      end
      if (i == rst_at) begin
        i_mac_valid = 1'b0; i_rst_n = 1'b0; @(posedge clk); #1; i_rst_n = 1'b1; break;
      end
      i_mac_data  = fr[i];
      i_mac_last  = (i == fr_len - 1);
      i_mac_valid = 1'b1;
      if (i == 27) t27 = cyc;
      @(posedge clk); #1;
    end
    i_mac_valid = 1'b0;
    i_mac_last  = 1'b0;
  endtask

  task automatic run_frame(input int gap);
    bit acc, grat, rep;
    logic [47:0] sha; logic [31:0] spa; logic [15:0] op;
    int t27;
    mon_vcnt = 0; mon_rcnt = 0;
    m_frame(gap, acc, grat, rep, sha, spa, op);
    send(gap, -1, t27);
    repeat (4) @(posedge clk);
    #1;
    chk("valid_pulses", 64'(mon_vcnt), 64'(acc || grat));
    chk("reply_pulses", 64'(mon_rcnt), 64'(rep));
    if (acc || grat) begin
      chk("target_mac", mon_mac, sha);
      chk("target_ip", mon_ip, spa);
      chk("target_op", mon_op, op);
      chk("latency", 64'(mon_cyc - t27), 64'd2);
    end
    chk("drop_cnt", o_drop_cnt, 64'(m_drop));
  endtask

  task automatic lookup(input logic [31:0] ip);
    bit hit; logic [47:0] mac;
    m_lookup(ip, hit, mac);
    i_lookup_ip = ip; i_lookup_valid = 1'b1;
    @(posedge clk); #1;
    i_lookup_valid = 1'b0;
    chk("lookup_done", o_lookup_done, 1);
    chk("lookup_hit", o_lookup_hit, 64'(hit));
    chk("lookup_mac", o_lookup_mac, mac);
    @(posedge clk); #1;
    chk("lookup_done_fall", o_lookup_done, 0);
  endtask

  task automatic chk_all_zero();
    chk("rst_mac", o_target_mac, 0);
    chk("rst_ip", o_target_ip, 0);
    chk("rst_op", o_target_op, 0);
    chk("rst_valid", o_target_valid, 0);
    chk("rst_reply", o_trig_reply, 0);
    chk("rst_lk_done", o_lookup_done, 0);
    chk("rst_lk_hit", o_lookup_hit, 0);
    chk("rst_lk_mac", o_lookup_mac, 0);
    chk("rst_drop", o_drop_cnt, 0);
  endtask

  function automatic logic [31:0] ip4(input logic [7:0] d);
    return {8'd192, 8'd168, 8'd1, d};
  endfunction

  initial begin
    int t27, kind;
    bit pre_hit, seen;
    logic [47:0] pre_mac;
    logic [31:0] ip;
    m_reset();
    repeat (3) @(posedge clk);
    #1 i_rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all_zero();

    // Request to local IP, then resolve the sender.
    build(16'd1, 48'h001122334455, ip4(1), LOCAL, 0);
    run_frame(-1);
    lookup(ip4(1));

    // Reply with padding drains without a drop.
    build(16'd2, 48'h0A0B0C0D0E0F, ip4(8), LOCAL, 18);
    run_frame(-1);

    // Bad frames in turn.
    build(16'd1, 48'h111111111111, ip4(20), LOCAL, 0);
    fr[2] = 8'h86; fr[3] = 8'hDD;
    run_frame(-1);
    build(16'd1, 48'h222222222222, ip4(21), ip4(9), 0);
    run_frame(-1);
    build(16'd1, 48'h333333333333, ip4(22), LOCAL, 0);
    fr_len = 21;
    run_frame(-1);
    build(16'd1, 48'h444444444444, ip4(23), LOCAL, 0);
    run_frame(10);
    chk("drop_four", o_drop_cnt, 4);

    // Reset mid-frame clears everything.
    build(16'd1, 48'h555555555555, ip4(24), LOCAL, 0);
    send(-1, 15, t27);
    m_reset();
    chk_all_zero();
    lookup(ip4(1));
    build(16'd1, 48'h001122334455, ip4(1), LOCAL, 0);
    run_frame(-1);

    // Fill, replace at pointer, then reallocate the evicted sender.
    for (int s = 3; s <= 6; s++) begin
      build(16'd2, {40'hC0FFEE0000, 8'(s)}, ip4(8'(s)), LOCAL, 0);
      run_frame(-1);
    end
    build(16'd1, 48'hDEADBEEF0001, ip4(1), LOCAL, 0);
    run_frame(-1);
    lookup(ip4(1));
    lookup(ip4(3));
    lookup(ip4(4));
    lookup(ip4(6));

    // Lookup coinciding with the cache write sees old contents.
    build(16'd1, 48'hABCDEF012345, ip4(7), LOCAL, 0);
    m_lookup(ip4(7), pre_hit, pre_mac);
    begin
      bit acc, grat, rep; logic [47:0] sha; logic [31:0] spa; logic [15:0] op;
      m_frame(-1, acc, grat, rep, sha, spa, op);
    end
    send(-1, -1, t27);
    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (o_target_valid) seen = 1;
    end
    chk("coincide_seen", seen, 1);
    i_lookup_ip = ip4(7); i_lookup_valid = 1'b1;
    @(negedge clk);
    chk("coincide_hit", o_lookup_hit, 64'(pre_hit));
    @(negedge clk);
    i_lookup_valid = 1'b0;
    chk("after_hit", o_lookup_hit, 1);
    chk("after_mac", o_lookup_mac, 48'hABCDEF012345);
    @(posedge clk); #1;

    // Local IP reprogramming.
    i_local_ip = ip4(99); i_local_ip_valid = 1'b1;
    @(posedge clk); #1;
    i_local_ip_valid = 1'b0;
    m_local = ip4(99);
    build(16'd1, 48'h0000000000AA, ip4(40), ip4(99), 1);
    run_frame(-1);
    build(16'd1, 48'h0000000000BB, ip4(41), LOCAL, 0);
    run_frame(-1);
    i_local_ip = LOCAL; i_local_ip_valid = 1'b1;
    @(posedge clk); #1;
    i_local_ip_valid = 1'b0;
    m_local = LOCAL;

    // Randomised frames mixed with lookups.
    for (int k = 0; k < 40; k++) begin
      int gap;
      gap  = -1;
      kind = $urandom_range(0, 6);
      ip   = ip4(8'($urandom_range(10, 15)));
      build((kind == 1) ? 16'd2 : 16'd1, {16'h0200, 32'($urandom)}, ip,
            (kind == 2) ? ip4(8'($urandom_range(16, 250))) : (kind == 6 ? ip : LOCAL),
            $urandom_range(0, 4));
      if (kind == 3) fr[$urandom_range(0, 7)] ^= 8'(1 << $urandom_range(0, 7));
      if (kind == 4) fr_len = $urandom_range(1, 27);
      if (kind == 5) gap = $urandom_range(1, 26);
      run_frame(gap);
      lookup(ip4(8'($urandom_range(10, 15))));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
